// File: rtl/hazard_pkg.sv
// Shared types for the hazard/forwarding controller.
// Slot fields use fixed ceilings so one struct serves every instance.
package hazard_pkg;

   localparam int SLOT_RD_W  = 8;
   localparam int SLOT_LAT_W = 4;

   localparam int FWD_RF    = 0;
   localparam int FWD_EXMEM = 1;
   localparam int FWD_MEMWB = 2;

   localparam int LAT_ALU  = 1;
   localparam int LAT_LOAD = 2;

   typedef struct packed {
      logic                  valid;
      logic [SLOT_RD_W-1:0]  rd;
      logic [SLOT_LAT_W-1:0] lat;
   } slot_t;

endpackage

// File: rtl/hazard_age_pipe.sv
// Age-ordered shift register of in-flight register writes.
// Index k holds the instruction k+1 cycles past issue.
module hazard_age_pipe
   import hazard_pkg::*;
#(
   parameter int DEPTH     = 2,
   parameter int FLUSH_AGE = 2
) (
   input  logic  clock,
   input  logic  reset_n,
   input  logic  advance_i,
   input  logic  flush_i,
   input  slot_t slot_i,
   output slot_t slots_o [DEPTH]
);

   slot_t slots_q [DEPTH];
   slot_t slots_d [DEPTH];

   // Flush kills by pre-shift age: index k-1 has age k.
   always_comb begin
      for (int k = 0; k < DEPTH; k++) begin
         slots_d[k] = slots_q[k];
      end
      if (advance_i) begin
         slots_d[0] = slot_i;
         for (int k = 1; k < DEPTH; k++) begin
            slots_d[k] = slots_q[k-1];
            if (flush_i && k < FLUSH_AGE) begin
               slots_d[k].valid = 1'b0;
            end
         end
      end
   end

   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         for (int k = 0; k < DEPTH; k++) begin
            slots_q[k] <= '0;
         end
      end else begin
         for (int k = 0; k < DEPTH; k++) begin
            slots_q[k] <= slots_d[k];
         end
      end
   end

   assign slots_o = slots_q;

endmodule

// File: rtl/hazard_forward_unit.sv
// Load-use / latency stall, flush bubble and operand forwarding
// control, driven from a tracker of in-flight register writes.
module hazard_forward_unit
   import hazard_pkg::*;
#(
   parameter int REG_W     = 5,
   parameter int FWD_DEPTH = 2,
   parameter int LAT_W     = 2,
   parameter int FLUSH_AGE = 2,
   parameter int CNT_W     = 16
) (
   input  logic                           clock,
   input  logic                           reset_n,
   input  logic                           id_valid,
   input  logic [REG_W-1:0]               id_rs,
   input  logic [REG_W-1:0]               id_rt,
   input  logic                           id_rs_used,
   input  logic                           id_rt_used,
   input  logic [REG_W-1:0]               id_rd,
   input  logic                           id_reg_write,
   input  logic [LAT_W-1:0]               id_lat,
   input  logic                           flush,
   input  logic                           hold,
   output logic                           issue,
   output logic                           stall,
   output logic                           pc_write,
   output logic                           ifid_write,
   output logic                           bubble,
   output logic [$clog2(FWD_DEPTH+1)-1:0] fwd_a,
   output logic [$clog2(FWD_DEPTH+1)-1:0] fwd_b,
   output logic [CNT_W-1:0]               stall_cnt
);

   localparam int FW = $clog2(FWD_DEPTH+1);

   slot_t          slots [FWD_DEPTH];
   slot_t          new_slot;
   logic           advance;
   logic           haz_a, haz_b;
   logic [FW-1:0]  sel_a, sel_b;
   logic [FW-1:0]  fwd_a_q, fwd_a_d;
   logic [FW-1:0]  fwd_b_q, fwd_b_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;

   // Scan oldest to youngest so the youngest match wins.
   function automatic logic [FW:0] lookup(
      input logic [REG_W-1:0] src,
      input logic             used
   );
      logic hit;
      int   age;
      int   lat;
      hit = 1'b0;
      age = 0;
      lat = 0;
      for (int k = FWD_DEPTH-1; k >= 0; k--) begin
         if (used && src != '0 && slots[k].valid &&
             slots[k].rd == SLOT_RD_W'(src)) begin
            hit = 1'b1;
            age = k + 1;
            lat = int'(slots[k].lat);
         end
      end
      if (hit && age < lat) return {1'b1, FW'(FWD_RF)};
      if (hit)              return {1'b0, FW'(age)};
      return {1'b0, FW'(FWD_RF)};
   endfunction

   assign {haz_a, sel_a} = lookup(id_rs, id_rs_used);
   assign {haz_b, sel_b} = lookup(id_rt, id_rt_used);

   assign stall      = haz_a | haz_b;
   assign issue      = id_valid & ~stall & ~hold & ~flush;
   assign bubble     = stall | flush | hold;
   assign pc_write   = ~stall & ~hold;
   assign ifid_write = ~stall & ~hold;
   assign advance    = ~hold | flush;

   always_comb begin
      new_slot.valid = issue & id_reg_write & (id_rd != '0);
      new_slot.rd    = SLOT_RD_W'(id_rd);
      new_slot.lat   = (id_lat == '0) ? SLOT_LAT_W'(LAT_ALU)
                                      : SLOT_LAT_W'(id_lat);
   end

   hazard_age_pipe #(
      .DEPTH     (FWD_DEPTH),
      .FLUSH_AGE (FLUSH_AGE)
   ) u_age_pipe (
      .clock     (clock),
      .reset_n   (reset_n),
      .advance_i (advance),
      .flush_i   (flush),
      .slot_i    (new_slot),
      .slots_o   (slots)
   );

   always_comb begin
      fwd_a_d = '0;
      fwd_b_d = '0;
      if (issue) begin
         fwd_a_d = sel_a;
         fwd_b_d = sel_b;
      end else if (hold && !flush) begin
         fwd_a_d = fwd_a_q;
         fwd_b_d = fwd_b_q;
      end
   end

   always_comb begin
      cnt_d = cnt_q;
      if (stall && !hold && !flush && cnt_q != '1) begin
         cnt_d = cnt_q + 1'b1;
      end
   end

   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         fwd_a_q <= '0;
         fwd_b_q <= '0;
         cnt_q   <= '0;
      end else begin
         fwd_a_q <= fwd_a_d;
         fwd_b_q <= fwd_b_d;
         cnt_q   <= cnt_d;
      end
   end

   assign fwd_a     = fwd_a_q;
   assign fwd_b     = fwd_b_q;
   assign stall_cnt = cnt_q;

endmodule

// File: tb/tb_hazard_forward_unit.sv
// Directed bench for hazard_forward_unit with an in-bench
// list-of-writes model checked every cycle.
module tb_hazard_forward_unit;

   localparam int D  = 2;
   localparam int FA = 2;

   logic       clock = 1'b0;
   logic       reset_n;
   logic       id_valid;
   logic [4:0] id_rs, id_rt, id_rd;
   logic       id_rs_used, id_rt_used, id_reg_write;
   logic [1:0] id_lat;
   logic       flush, hold;
   logic       issue, stall, pc_write, ifid_write, bubble;
   logic [1:0] fwd_a, fwd_b;
   logic [15:0] stall_cnt;

   always #5 clock = ~clock;

   hazard_forward_unit #(
      .REG_W(5), .FWD_DEPTH(D), .LAT_W(2), .FLUSH_AGE(FA), .CNT_W(16)
   ) dut (
      .clock(clock), .reset_n(reset_n), .id_valid(id_valid),
      .id_rs(id_rs), .id_rt(id_rt),
      .id_rs_used(id_rs_used), .id_rt_used(id_rt_used),
      .id_rd(id_rd), .id_reg_write(id_reg_write), .id_lat(id_lat),
      .flush(flush), .hold(hold), .issue(issue), .stall(stall),
      .pc_write(pc_write), .ifid_write(ifid_write), .bubble(bubble),
      .fwd_a(fwd_a), .fwd_b(fwd_b), .stall_cnt(stall_cnt)
   );

   int n_chk  = 0;
   int n_pass = 0;

   task automatic chk(input string nm, input int act, input int exp);
      n_chk++;
      if (act == exp) n_pass++;
      else $display("FAIL %s: got %0d expected %0d at %0t",
                    nm, act, exp, $time);
   endtask

   // Model: a list of in-flight writes, each with its own age.
   typedef struct {
      int rd;
      int lat;
      int age;
   } w_t;

   w_t q[$];
   w_t tmp[$];
   w_t ent;
   int m_fa, m_fb, m_cnt;
   bit p_st, p_is;
   int p_sa, p_sb;
   bit c_st, c_is;
   int c_sa, c_sb;

   task automatic look(input int s, input bit used,
                       output bit haz, output int sel);
      int best;
      int bl;
      best = 1000;
      bl   = 0;
      foreach (q[i]) begin
         if (used && s != 0 && q[i].rd == s && q[i].age < best) begin
            best = q[i].age;
            bl   = q[i].lat;
         end
      end
      haz = (best < 1000) && (best < bl);
      sel = (best < 1000 && !haz) ? best : 0;
   endtask

   task automatic expect_comb(output bit st, output bit is,
                              output int sa, output int sb);
      bit ha, hb;
      look(int'(id_rs), id_rs_used, ha, sa);
      look(int'(id_rt), id_rt_used, hb, sb);
      st = ha | hb;
      is = id_valid && !st && !hold && !flush;
   endtask

   initial begin
      q.delete();
      m_fa = 0; m_fb = 0; m_cnt = 0;
      forever begin
         @(posedge clock or negedge reset_n);
         if (!reset_n) begin
            q.delete();
            m_fa = 0; m_fb = 0; m_cnt = 0;
         end else begin
            expect_comb(p_st, p_is, p_sa, p_sb);
            if (p_is) begin
               m_fa = p_sa; m_fb = p_sb;
            end else if (!(hold && !flush)) begin
               m_fa = 0; m_fb = 0;
            end
            if (p_st && !hold && !flush && m_cnt < 65535) m_cnt++;
            if (!hold || flush) begin
               tmp.delete();
               foreach (q[i]) begin
                  if (!(flush && q[i].age < FA) && q[i].age + 1 <= D) begin
                     ent     = q[i];
                     ent.age = q[i].age + 1;
                     tmp.push_back(ent);
                  end
               end
               if (p_is && id_reg_write && id_rd != 0) begin
                  ent.rd  = int'(id_rd);
                  ent.lat = (id_lat == 0) ? 1 : int'(id_lat);
                  ent.age = 1;
                  tmp.push_back(ent);
               end
               q = tmp;
            end
         end
      end
   end

   initial begin
      forever begin
         @(negedge clock);
         expect_comb(c_st, c_is, c_sa, c_sb);
         chk("m_stall", stall, c_st);
         chk("m_issue", issue, c_is);
         chk("m_bubble", bubble, c_st | flush | hold);
         chk("m_pc_write", pc_write, !c_st && !hold);
         chk("m_ifid_write", ifid_write, !c_st && !hold);
         chk("m_fwd_a", fwd_a, m_fa);
         chk("m_fwd_b", fwd_b, m_fb);
         chk("m_stall_cnt", stall_cnt, m_cnt);
      end
   end

   initial begin
      #100000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1);
   end

   task automatic idle();
      id_valid = 0; id_rs = 0; id_rt = 0; id_rs_used = 0;
      id_rt_used = 0; id_rd = 0; id_reg_write = 0; id_lat = 0;
   endtask

   task automatic ins(input int rs, input int rsu, input int rt,
                      input int rtu, input int rd, input int rw,
                      input int lat);
      id_valid = 1;
      id_rs = 5'(rs); id_rs_used = rsu[0];
      id_rt = 5'(rt); id_rt_used = rtu[0];
      id_rd = 5'(rd); id_reg_write = rw[0];
      id_lat = 2'(lat);
   endtask

   task automatic half();
      @(negedge clock); #1;
   endtask

   task automatic fin();
      @(posedge clock); #1;
   endtask

   initial begin
      idle(); flush = 0; hold = 0; reset_n = 0;
      repeat (2) @(posedge clock);
      #1;
      chk("rst_stall", stall, 0);
      chk("rst_pc_write", pc_write, 1);
      chk("rst_fwd_a", fwd_a, 0);
      chk("rst_cnt", stall_cnt, 0);
      reset_n = 1;

      // load r3, then add r4,r3,r5
      ins(0, 0, 0, 0, 3, 1, 2); half(); chk("ld_issue", issue, 1); fin();
      ins(3, 1, 5, 1, 4, 1, 1); half();
      chk("lu_stall", stall, 1);
      chk("lu_pc_write", pc_write, 0);
      chk("lu_bubble", bubble, 1);
      chk("lu_issue0", issue, 0);
      fin();
      half(); chk("lu_issue", issue, 1); chk("lu_stall2", stall, 0); fin();
      idle(); half();
      chk("lu_fwd_a", fwd_a, 2);
      chk("lu_cnt", stall_cnt, 1);
      fin();

      // ALU producer r7 at distances 1, 2, 3
      ins(0, 0, 0, 0, 7, 1, 1); fin();
      ins(0, 0, 7, 1, 10, 1, 1); half(); chk("alu_nostall", stall, 0); fin();
      idle(); half(); chk("alu_fwd_b1", fwd_b, 1); fin();
      ins(0, 0, 0, 0, 7, 1, 1); fin();
      idle(); fin();
      ins(0, 0, 7, 1, 0, 0, 1); fin();
      idle(); half(); chk("alu_fwd_b2", fwd_b, 2); fin();
      ins(0, 0, 0, 0, 7, 1, 1); fin();
      idle(); fin(); fin();
      ins(0, 0, 7, 1, 0, 0, 1); fin();
      idle(); half(); chk("alu_fwd_b0", fwd_b, 0); fin();

      // two writers of r9: youngest wins
      ins(0, 0, 0, 0, 9, 1, 1); fin();
      ins(0, 0, 0, 0, 9, 1, 1); fin();
      ins(9, 1, 0, 0, 11, 1, 1); fin();
      idle(); half(); chk("same_rd_fwd_a", fwd_a, 1); fin();

      // flush with load-use pending
      fin(); fin();
      ins(0, 0, 0, 0, 2, 1, 2); fin();
      ins(2, 1, 0, 0, 12, 1, 1); flush = 1; half();
      chk("fl_issue", issue, 0);
      chk("fl_bubble", bubble, 1);
      fin();
      flush = 0; half();
      chk("fl_nostall", stall, 0);
      chk("fl_issue2", issue, 1);
      chk("fl_cnt", stall_cnt, 1);
      fin();
      idle(); half(); chk("fl_fwd_a", fwd_a, 0); fin();

      // hold for 3 cycles with a load at age 1
      fin(); fin();
      ins(0, 0, 0, 0, 6, 1, 2); fin();
      ins(6, 1, 0, 0, 13, 1, 1); hold = 1;
      repeat (3) begin
         half();
         chk("hold_pc_write", pc_write, 0);
         chk("hold_issue", issue, 0);
         chk("hold_stall", stall, 1);
         fin();
      end
      hold = 0; half(); chk("hold_rel_stall", stall, 1); fin();
      half(); chk("hold_rel_issue", issue, 1); fin();
      idle(); half();
      chk("hold_fwd_a", fwd_a, 2);
      chk("hold_cnt", stall_cnt, 2);
      fin();

      // r0 is never tracked
      ins(0, 0, 0, 0, 0, 1, 2); fin();
      ins(0, 1, 0, 0, 14, 1, 1); half();
      chk("r0_stall", stall, 0);
      chk("r0_issue", issue, 1);
      fin();
      idle(); half(); chk("r0_fwd_a", fwd_a, 0); fin();

      // reset mid-stall
      ins(0, 0, 0, 0, 8, 1, 2); fin();
      ins(8, 1, 0, 0, 15, 1, 1); half();
      chk("mr_stall", stall, 1);
      chk("mr_cnt_pre", stall_cnt, 2);
      reset_n = 0; #1;
      chk("mr_stall0", stall, 0);
      chk("mr_cnt0", stall_cnt, 0);
      chk("mr_pc_write", pc_write, 1);
      idle(); fin();
      reset_n = 1; half();
      chk("mr_noissue", issue, 0);
      chk("mr_fwd_a", fwd_a, 0);
      fin();
      repeat (3) fin();

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

endmodule

// File: doc/hazard_forward_unit.md
# hazard_forward_unit

Parametrised hazard-detection and forwarding controller for the pipelined core, replacing the separate load-use detector, forwarding unit and control-bubble mux with one stateful block. It sits beside the ID stage and tracks every in-flight register write in an age-ordered shift pipeline. From that state it decides whether the ID instruction issues, stalls (load-use or longer latencies) or is squashed by a taken branch. It also registers forwarding selects for both source operands.

## Interface
Parameters:
- REG_W, 5, register address width
- FWD_DEPTH, 2, stages between EX and write-back that can supply forwarded data; the default 2 covers EX/MEM and MEM/WB
- LAT_W, 2, width of the per-instruction result latency field
- FLUSH_AGE, 2, entries with age < FLUSH_AGE are cancelled on flush
- CNT_W, 16, stall counter width

Ports:
- clock  in  1  single clock, rising edge
- reset_n  in  1  asynchronous, active-low reset
- id_valid  in  1  ID holds a real instruction
- id_rs, id_rt  in  REG_W  source registers
- id_rs_used, id_rt_used  in  1  source is actually read
- id_rd  in  REG_W  destination register
- id_reg_write  in  1  instruction writes id_rd
- id_lat  in  LAT_W  latency code: 1 = ALU, 2 = load; 0 is treated as 1
- flush  in  1  branch taken, resolved in MEM
- hold  in  1  external freeze (memory wait)
- issue  out  1  ID instruction enters EX this cycle
- stall  out  1  data-hazard stall
- pc_write, ifid_write  out  1  PC / IF-ID enables
- bubble  out  1  zero ID/EX control fields
- fwd_a, fwd_b  out  $clog2(FWD_DEPTH+1)  registered operand selects for EX
- stall_cnt  out  CNT_W  saturating count of stall cycles

## Operation
- The tracker has slots 1..FWD_DEPTH. Each slot holds {valid, rd, lat}. Slot k holds the instruction k cycles past issue.
- On every advancing edge (hold=0), slot k moves to slot k+1 and slot FWD_DEPTH retires.
  - Slot 1 loads {issue & id_reg_write & (id_rd≠0), id_rd, max(id_lat,1)}.
  - Otherwise slot 1 loads a bubble.
- Match: source s is matched when s_used, s≠0, and some slot is valid with rd==s. Only the youngest (lowest-age) matching slot counts.
- Hazard: a matched slot with age k and k < lat raises stall.
- Forward select for s: the age k of the youngest matching slot when k ≥ lat, otherwise 0 (register file). The register file is write-first, so retired writes need no bypass.
- Combinational outputs:
  - issue = id_valid & ~stall & ~hold & ~flush
  - bubble = stall | flush | hold
  - pc_write = ifid_write = ~stall & ~hold
- On flush:
  - The ID instruction is not issued.
  - Slots with age < FLUSH_AGE are invalidated in the same edge's update.
  - flush overrides hold: the tracker still advances.
- fwd_a / fwd_b are registered on issue. They are cleared to 0 on a bubble edge, and held on a hold edge.
- stall_cnt increments on edges where stall & ~hold & ~flush. It saturates at all-ones.

## Timing
- Reset (asynchronous, reset_n=0): all slots invalid, fwd_a = fwd_b = 0, stall_cnt = 0. Combinational outputs then follow from the empty tracker: stall = 0 and pc_write = ifid_write = 1.
- stall, issue, bubble, pc_write and ifid_write are combinational, with zero-cycle latency from ID inputs and tracker state.
- fwd_a / fwd_b are valid in the cycle after issue, aligned with the consumer in EX.
- Load-use: producer lat=2 at age 1 gives exactly 1 stall cycle, then fwd=2 (MEM/WB).
- A lat=1 producer gives zero stall and fwd=1 (EX/MEM).
- When two in-flight writers target the same rd, the younger one wins the forward.
- rd=0 is never tracked.
- Simultaneous hazard and flush: the flush wins, and stall_cnt is not incremented.
- Reset asserted mid-stall clears all state immediately. No issue is pending after release.

## Structure
- Shared package hazard_pkg:
  - slot struct {valid, rd, lat}
  - fwd encodings FWD_RF=0, FWD_EXMEM=1, FWD_MEMWB=2
  - latency codes LAT_ALU=1, LAT_LOAD=2
- One natural sub-module: hazard_age_pipe, the slot shift register with hold/flush invalidation. It exposes the slot vector to the top-level match logic.

## Test plan
- Load to r3 (lat 2), then `add r4,r3,r5` next cycle: stall=1 for 1 cycle with pc_write=0 and bubble=1; then issue=1, fwd_a=2, stall_cnt=1.
- ALU writes r7, consumer reads r7 next cycle: no stall, fwd_b=1. Consumer two cycles later: fwd_b=2. Three cycles later: fwd_b=0.
- Two consecutive ALU writes to r9, then a reader of r9: fwd_a=1 (the youngest).
- Load r2, then flush asserted in the cycle the dependent sits in ID: issue=0 and stall_cnt is unchanged. The age-1 slot is invalidated, and the next instruction reading r2 sees no hazard.
- hold=1 for 3 cycles with a load at age 1: tracker frozen, pc_write=0. After release, exactly 1 stall cycle occurs.
- Write to r0 with lat 2, then a reader of r0: no stall, fwd=0. Drive reset_n low mid-stall: stall=0 and stall_cnt=0 asynchronously.
